// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the sequencer state encoding and the counter sizing rule.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    OFF,
    PD_HOLD,
    WAIT_LOCK,
    SEQ,
    RUN,
    SHUT
  } state_t;

  localparam int RETRY_W = 4;

  // Width able to hold the value n itself; at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-flop synchroniser with asynchronous clear.
// Used both for the raw PLL lock and for the reset-release chain (d tied high).
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Power-up, lock qualification, staggered output enable and lock-loss retry
// controller for a CCC/PLL, running on the free-running reference clock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_OUT          = 1,
  parameter int SYNC_STAGES      = 2,
  parameter int PD_HOLD_CYC      = 64,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 16,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               enable,
  input  logic               force_relock,
  input  logic               clr_fault,
  input  logic               pll_lock,
  output logic               pll_powerdown_n,
  output logic [NUM_OUT-1:0] out_en,
  output logic               locked,
  output logic               fault,
  output logic [3:0]         retry_cnt,
  output logic [CNT_W-1:0]   lol_cnt
);

  // One phase counter serves the power-down hold and both stagger sequences.
  localparam int PH_MAX = (PD_HOLD_CYC > STAGGER_CYC) ? PD_HOLD_CYC : STAGGER_CYC;
  localparam int PH_W   = cnt_width(PH_MAX);
  localparam int STAB_W = cnt_width(LOCK_STABLE_CYC);
  localparam int TMO_W  = cnt_width(LOCK_TIMEOUT_CYC);

  localparam logic [PH_W-1:0]    HOLD_LAST   = PH_W'(PD_HOLD_CYC - 1);
  localparam logic [PH_W-1:0]    STAG_LAST   = PH_W'(STAGGER_CYC - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST   = STAB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);

  logic rst_n;
  logic lock_s;

  state_t               state_q,  state_d;
  logic [PH_W-1:0]      phase_q,  phase_d;
  logic [STAB_W-1:0]    stab_q,   stab_d;
  logic [TMO_W-1:0]     tmo_q,    tmo_d;
  logic [NUM_OUT-1:0]   out_en_q, out_en_d;
  logic                 fault_q,  fault_d;
  logic [RETRY_W-1:0]   retry_q,  retry_d;
  logic [CNT_W-1:0]     lol_q,    lol_d;
  logic                 do_retry;
  logic [RETRY_W-1:0]   retry_inc;

  // Assert immediately, release two reference clocks after arst_n rises.
  pll_sup_sync #(.STAGES(2)) u_rst_sync (
    .clk   (clk),
    .rst_n (arst_n),
    .d     (1'b1),
    .q     (rst_n)
  );

  pll_sup_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    phase_d  = phase_q;
    stab_d   = '0;
    tmo_d    = '0;
    out_en_d = out_en_q;
    fault_d  = fault_q;
    retry_d  = retry_q;
    lol_d    = lol_q;
    do_retry = 1'b0;

    if (clr_fault) begin
      fault_d = 1'b0;
      retry_d = '0;
    end

    case (state_q)
      OFF: begin
        out_en_d = '0;
        phase_d  = '0;
        // A clear pulse lets bring-up start in the very next cycle.
        if (enable && (!fault_q || clr_fault)) state_d = PD_HOLD;
      end

      PD_HOLD: begin
        if (!enable) begin
          state_d = OFF;
        end else if (phase_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      WAIT_LOCK: begin
        stab_d = lock_s ? stab_q + STAB_W'(1) : '0;
        tmo_d  = tmo_q + TMO_W'(1);
        if (!enable) begin
          state_d = OFF;
        end else if (lock_s && (stab_q == STAB_LAST)) begin
          state_d  = SEQ;
          out_en_d = NUM_OUT'(1);
          phase_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          do_retry = 1'b1;
        end else if (force_relock) begin
          state_d = PD_HOLD;
          phase_d = '0;
        end
      end

      SEQ: begin
        if (!enable) begin
          state_d  = SHUT;
          out_en_d = out_en_q >> 1;
          phase_d  = '0;
        end else if (force_relock) begin
          state_d  = PD_HOLD;
          out_en_d = '0;
          phase_d  = '0;
        end else if (out_en_q[NUM_OUT-1]) begin
          state_d = RUN;
          retry_d = '0;
        end else if (phase_q == STAG_LAST) begin
          // Enables form a thermometer code filling upward from bit 0.
          out_en_d = NUM_OUT'({out_en_q, 1'b1});
          phase_d  = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      RUN: begin
        if (!enable) begin
          state_d  = SHUT;
          out_en_d = out_en_q >> 1;
          phase_d  = '0;
        end else if (!lock_s) begin
          do_retry = 1'b1;
          lol_d    = (lol_q == '1) ? lol_q : lol_q + CNT_W'(1);
        end else if (force_relock) begin
          state_d  = PD_HOLD;
          out_en_d = '0;
          phase_d  = '0;
        end
      end

      SHUT: begin
        if (out_en_q == '0) begin
          state_d = OFF;
        end else if (phase_q == STAG_LAST) begin
          out_en_d = out_en_q >> 1;
          phase_d  = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      default: begin
        state_d  = OFF;
        out_en_d = '0;
      end
    endcase

    // Counts from the pre-clear value so a fault raised alongside clr_fault wins.
    if (do_retry) begin
      out_en_d = '0;
      phase_d  = '0;
      retry_d  = retry_inc;
      if (retry_inc >= MAX_RETRY_V) begin
        fault_d = 1'b1;
        state_d = OFF;
      end else begin
        state_d = PD_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      phase_q  <= '0;
      stab_q   <= '0;
      tmo_q    <= '0;
      out_en_q <= '0;
      fault_q  <= 1'b0;
      retry_q  <= '0;
      lol_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      stab_q   <= stab_d;
      tmo_q    <= tmo_d;
      out_en_q <= out_en_d;
      fault_q  <= fault_d;
      retry_q  <= retry_d;
      lol_q    <= lol_d;
    end
  end

  assign pll_powerdown_n = state_q inside {WAIT_LOCK, SEQ, RUN, SHUT};
  assign out_en          = out_en_q;
  assign locked          = (state_q == RUN);
  assign fault           = fault_q;
  assign retry_cnt       = retry_q;
  assign lol_cnt         = lol_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expectations are queued as stimulus
// is applied and popped when the corresponding DUT response is measured.
module tb_pll_lock_supervisor;

  localparam int NUM_OUT = 4;
  localparam int SYNC    = 2;
  localparam int PD_HOLD = 64;
  localparam int STABLE  = 256;
  localparam int TIMEOUT = 1000;
  localparam int STAGGER = 16;
  localparam int RETRIES = 3;
  localparam int CNT_W   = 8;

  localparam int S_PD  = 0;
  localparam int S_EN  = 1;
  localparam int S_LK  = 2;
  localparam int S_FLT = 3;
  localparam int S_RTY = 4;
  localparam int S_LOL = 5;
  localparam int S_ALL = 6;

  // Edges from the first WAIT_LOCK cycle (lock already synchronised) to LOCKED.
  localparam int LOCK_TO_RUN = STABLE + (NUM_OUT - 1) * STAGGER + 1;

  logic               clk          = 1'b0;
  logic               arst_n       = 1'b1;
  logic               enable       = 1'b0;
  logic               force_relock = 1'b0;
  logic               clr_fault    = 1'b0;
  logic               pll_lock     = 1'b0;
  logic               pll_powerdown_n;
  logic [NUM_OUT-1:0] out_en;
  logic               locked;
  logic               fault;
  logic [3:0]         retry_cnt;
  logic [CNT_W-1:0]   lol_cnt;

  pll_lock_supervisor #(
    .NUM_OUT          (NUM_OUT),
    .SYNC_STAGES      (SYNC),
    .PD_HOLD_CYC      (PD_HOLD),
    .LOCK_STABLE_CYC  (STABLE),
    .LOCK_TIMEOUT_CYC (TIMEOUT),
    .STAGGER_CYC      (STAGGER),
    .MAX_RETRY        (RETRIES),
    .CNT_W            (CNT_W)
  ) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .enable          (enable),
    .force_relock    (force_relock),
    .clr_fault       (clr_fault),
    .pll_lock        (pll_lock),
    .pll_powerdown_n (pll_powerdown_n),
    .out_en          (out_en),
    .locked          (locked),
    .fault           (fault),
    .retry_cnt       (retry_cnt),
    .lol_cnt         (lol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_PD:    return 32'(pll_powerdown_n);
      S_EN:    return 32'(out_en);
      S_LK:    return 32'(locked);
      S_FLT:   return 32'(fault);
      S_RTY:   return 32'(retry_cnt);
      S_LOL:   return 32'(lol_cnt);
      S_ALL:   return 32'({pll_powerdown_n, out_en, locked, fault, retry_cnt, lol_cnt});
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_q.push_back('{tag, val});
  endtask

  task automatic check(input logic [31:0] got);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%0d want=nothing", got);
      return;
    end
    e = exp_q.pop_front();
    assert (got === e.val) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", e.tag, got, e.val);
    end
  endtask

  // Counts clock edges until the selected output equals val; -1 if the budget runs out.
  task automatic wait_obs(input int sel, input logic [31:0] val, input int budget, output int n);
    n = 0;
    while (obs(sel) !== val && n <= budget) begin
      @(negedge clk);
      n++;
    end
    if (obs(sel) !== val) n = -1;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int         n;
    logic [3:0] seen;

    // Reset: everything low immediately on assertion, stays off after release.
    #3 arst_n = 1'b0;
    push("reset_outputs", 0);
    #1 check(obs(S_ALL));
    cycles(3);
    arst_n = 1'b1;
    cycles(4);
    push("off_pd_low", 0);
    check(obs(S_PD));

    // Bring-up: enable registers on one edge, then PD_HOLD lasts PD_HOLD cycles.
    push("pd_rise_after_enable", 1 + PD_HOLD);
    enable = 1'b1;
    wait_obs(S_PD, 1, 200, n);
    check(n);
    cycles(100);
    pll_lock = 1'b1;
    push("out_en0_after_lock", SYNC + STABLE);
    push("out_en1_stagger", STAGGER);
    push("out_en2_stagger", STAGGER);
    push("out_en3_stagger", STAGGER);
    push("locked_after_out_en3", 1);
    wait_obs(S_EN, 4'b0001, 400, n); check(n);
    wait_obs(S_EN, 4'b0011, 40, n);  check(n);
    wait_obs(S_EN, 4'b0111, 40, n);  check(n);
    wait_obs(S_EN, 4'b1111, 40, n);  check(n);
    wait_obs(S_LK, 1, 10, n);        check(n);

    // One-cycle lock drop in RUN.
    push("lol_out_en_clear", SYNC + 1);
    push("lol_cnt_1", 1);
    push("lol_retry_1", 1);
    push("lol_locked_drop", 0);
    push("lol_pd_low_cycles", PD_HOLD);
    push("lol_relock_cycles", LOCK_TO_RUN);
    push("lol_retry_cleared", 0);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    wait_obs(S_EN, 0, 10, n);
    check((n < 0) ? n : n + 1);
    check(obs(S_LOL));
    check(obs(S_RTY));
    check(obs(S_LK));
    wait_obs(S_PD, 1, 100, n);  check(n);
    wait_obs(S_LK, 1, 400, n);  check(n);
    check(obs(S_RTY));

    // FORCE_RELOCK alone: restart without counting a failure.
    push("fr_out_en_clear", 0);
    push("fr_retry_unchanged", 0);
    push("fr_pd_low", 0);
    push("fr_relock_cycles", PD_HOLD + LOCK_TO_RUN);
    push("fr_retry_after", 0);
    force_relock = 1'b1;
    @(negedge clk);
    force_relock = 1'b0;
    check(obs(S_EN));
    check(obs(S_RTY));
    check(obs(S_PD));
    wait_obs(S_LK, 1, 500, n);
    check(n);
    check(obs(S_RTY));

    // FORCE_RELOCK in the same cycle as synchronised loss of lock: loss wins.
    push("frlol_retry_1", 1);
    push("frlol_lol_cnt_2", 2);
    push("frlol_out_en_clear", 0);
    push("frlol_relock_cycles", PD_HOLD + LOCK_TO_RUN);
    push("frlol_retry_cleared", 0);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    @(negedge clk);
    force_relock = 1'b1;
    @(negedge clk);
    force_relock = 1'b0;
    check(obs(S_RTY));
    check(obs(S_LOL));
    check(obs(S_EN));
    wait_obs(S_LK, 1, 500, n);
    check(n);
    check(obs(S_RTY));

    // Orderly shutdown from RUN, highest channel first.
    push("shut_first_clear", 1);
    push("shut_locked_drop", 0);
    push("shut_0011", STAGGER);
    push("shut_0001", STAGGER);
    push("shut_0000", STAGGER);
    push("shut_pd_low", 1);
    enable = 1'b0;
    wait_obs(S_EN, 4'b0111, 5, n);  check(n);
    check(obs(S_LK));
    wait_obs(S_EN, 4'b0011, 40, n); check(n);
    wait_obs(S_EN, 4'b0001, 40, n); check(n);
    wait_obs(S_EN, 4'b0000, 40, n); check(n);
    wait_obs(S_PD, 0, 5, n);        check(n);

    // No lock at all: three timeouts latch FAULT.
    push("fault_after_timeouts", 1 + RETRIES * (PD_HOLD + TIMEOUT));
    push("fault_retry_cnt", RETRIES);
    push("fault_pd_low", 0);
    push("fault_out_en_off", 0);
    push("fault_ignores_enable", 0);
    push("fault_sticky", 1);
    push("clr_fault_clears", 0);
    push("clr_retry_zero", 0);
    push("restart_pd_rise", PD_HOLD);
    pll_lock = 1'b0;
    enable   = 1'b1;
    wait_obs(S_FLT, 1, 4000, n);
    check(n);
    check(obs(S_RTY));
    check(obs(S_PD));
    check(obs(S_EN));
    cycles(20);
    check(obs(S_PD));
    check(obs(S_FLT));
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    check(obs(S_FLT));
    check(obs(S_RTY));
    wait_obs(S_PD, 1, 100, n);
    check(n);

    // Chattering lock: 200-cycle highs never qualify, attempt times out.
    push("chatter_timeout", TIMEOUT);
    push("chatter_no_seq", 0);
    push("chatter_retry_1", 1);
    n    = 0;
    seen = '0;
    while (pll_powerdown_n === 1'b1 && n <= TIMEOUT + 100) begin
      pll_lock = ((n % 220) < 200);
      @(negedge clk);
      n++;
      seen |= out_en;
    end
    if (pll_powerdown_n !== 1'b0) n = -1;
    check(n);
    check(32'(seen));
    check(obs(S_RTY));

    // Asynchronous reset in the middle of SEQ.
    push("mid_seq_reached", 4'b0011);
    push("lol_before_reset", 2);
    push("async_reset_all_zero", 0);
    push("post_reset_pd_low", 0);
    pll_lock = 1'b1;
    wait_obs(S_EN, 4'b0011, 3000, n);
    check(obs(S_EN));
    check(obs(S_LOL));
    #2 arst_n = 1'b0;
    #1 check(obs(S_ALL));
    enable = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    cycles(5);
    check(obs(S_PD));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
